// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// TIMEOUT only has an effect in builds that define ARB_TIMEOUT_EN.
package rr_arbiter8_pkg;

  localparam int N       = 8;
  localparam int PW      = 3;
  localparam int TIMEOUT = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    state_t        state;
    logic [PW-1:0] ptr;
  } arb_dbg_t;

  // One-hot to index; returns 0 for an all-zero input.
  function automatic logic [PW-1:0] oh_idx(input logic [N-1:0] oh);
    oh_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) oh_idx = oh_idx | PW'(i);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter8_pick8.sv
// Combinational round-robin pick: the first set req bit at or above ptr
// (wrapping 7->0) comes out as a one-hot win vector.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);

  logic [N-1:0] rot;
  logic [N-1:0] sel;
  logic [PW:0]  back_shift;

  // rot[k] is req[(ptr+k) mod N], so bit 0 of rot is the highest-priority slot.
  assign rot        = N'({req, req} >> ptr);
  assign sel        = rot & (~rot + N'(1));
  assign back_shift = (PW+1)'(N) - {1'b0, ptr};
  assign win        = N'({sel, sel} >> back_shift);

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant.
// Define ARB_TIMEOUT_EN to revoke grants held longer than TIMEOUT cycles.
// The owner-release strobe is named rel because release is a reserved word.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         timeout,
  output arb_dbg_t     dbg
);

  // Handshake: req is level-sensitive and must stay high for as long as the
  // requester wants the grant; rel is a one-cycle pulse from the current
  // owner and is ignored while no grant is outstanding.

  state_t        state;
  logic [PW-1:0] ptr;
  logic [N-1:0]  win;
  logic          owner_gone;
  logic          exit_busy;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  assign owner_gone = ((req & grant) == '0);
  assign exit_busy  = rel | owner_gone;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt         <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req != '0) begin
            grant       <= win;
            grant_valid <= 1'b1;
            ptr         <= oh_idx(win) + PW'(1);
            state       <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
            cnt         <= '0;
`endif
          end
        end
        ST_BUSY: begin
          // Release / owner drop outrank the timer, so timeout stays low then.
          if (exit_busy) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= ST_IDLE;
`ifdef ARB_TIMEOUT_EN
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= ST_IDLE;
            timeout_q   <= 1'b1;
          end else begin
            cnt         <= cnt + CW'(1);
`endif
          end
        end
        default: begin
          state       <= ST_IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    dbg       = '0;
    dbg.state = state;
    dbg.ptr   = ptr;
  end

  a_grant_clean : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant) && (grant_valid == (|grant)));

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: vector table plus hand-written sequences
// for rotation, asynchronous reset and the optional grant timeout.
module tb_rr_arbiter8;
  import rr_arbiter8_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         rel;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic         timeout;
  arb_dbg_t     dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] exp_q[$];

  typedef struct {
    logic [7:0] req;
    logic       rel;
    logic [7:0] grant;
    logic [2:0] ptr;
  } vec_t;

  vec_t vecs[16];

  rr_arbiter8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .rel         (rel),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout     (timeout),
    .dbg         (dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic do_reset();
    req   = '0;
    rel   = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reference 8-to-3 encoder as seen downstream.
  function automatic logic [2:0] enc8(input logic [7:0] g);
    enc8 = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) enc8 = 3'(i);
  endfunction

  initial begin
    vecs[0]  = '{8'h24, 1'b0, 8'h04, 3'd3};
    vecs[1]  = '{8'h24, 1'b1, 8'h00, 3'd3};
    vecs[2]  = '{8'h24, 1'b0, 8'h20, 3'd6};
    vecs[3]  = '{8'h24, 1'b0, 8'h20, 3'd6};
    vecs[4]  = '{8'h04, 1'b0, 8'h00, 3'd6};
    vecs[5]  = '{8'h04, 1'b0, 8'h04, 3'd3};
    vecs[6]  = '{8'h04, 1'b1, 8'h00, 3'd3};
    vecs[7]  = '{8'h08, 1'b0, 8'h08, 3'd4};
    vecs[8]  = '{8'h18, 1'b0, 8'h08, 3'd4};
    vecs[9]  = '{8'h10, 1'b0, 8'h00, 3'd4};
    vecs[10] = '{8'h10, 1'b0, 8'h10, 3'd5};
    vecs[11] = '{8'h10, 1'b1, 8'h00, 3'd5};
    vecs[12] = '{8'h11, 1'b0, 8'h01, 3'd1};
    vecs[13] = '{8'h11, 1'b1, 8'h00, 3'd1};
    vecs[14] = '{8'h00, 1'b1, 8'h00, 3'd1};
    vecs[15] = '{8'h00, 1'b0, 8'h00, 3'd1};

    // ---------------- reset state ----------------
    req   = '0;
    rel   = 1'b0;
    rst_n = 1'b0;
    #3;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_valid", 32'(grant_valid), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);
    check("reset_ptr", 32'(dbg.ptr), 32'h0);
    check("reset_state", 32'(dbg.state), 32'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- vector table ----------------
    for (int v = 0; v < 16; v++) begin
      req = vecs[v].req;
      rel = vecs[v].rel;
      tick();
      check($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].grant));
      check($sformatf("vec%0d_valid", v), 32'(grant_valid), 32'(vecs[v].grant != 8'h00));
      check($sformatf("vec%0d_ptr", v), 32'(dbg.ptr), 32'(vecs[v].ptr));
      check($sformatf("vec%0d_timeout", v), 32'(timeout), 32'h0);
    end
    rel = 1'b0;
    req = '0;
    tick();

    // ---------------- fairness rotation, all requesting ----------------
    do_reset();
    for (int k = 0; k < 9; k++) exp_q.push_back(8'(1 << (k % 8)));
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] g;
      g   = exp_q.pop_front();
      rel = 1'b0;
      tick();
      check($sformatf("rot%0d_grant", k), 32'(grant), 32'(g));
      check($sformatf("rot%0d_enc", k), 32'(enc8(grant)), 32'(k % 8));
      check($sformatf("rot%0d_valid", k), 32'(grant_valid), 32'h1);
      tick();
      check($sformatf("rot%0d_hold", k), 32'(grant), 32'(g));
      rel = 1'b1;
      tick();
      check($sformatf("rot%0d_gap", k), 32'(grant), 32'h0);
      check($sformatf("rot%0d_gap_valid", k), 32'(grant_valid), 32'h0);
    end
    rel = 1'b0;

    // ---------------- asynchronous reset mid-grant ----------------
    req = 8'h40;
    tick();
    check("pre_rst_grant", 32'(grant), 32'h40);
    check("pre_rst_enc", 32'(enc8(grant)), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 32'h0);
    check("async_rst_valid", 32'(grant_valid), 32'h0);
    check("async_rst_ptr", 32'(dbg.ptr), 32'h0);
    #1;
    req   = 8'h81;
    rst_n = 1'b1;
    tick();
    check("post_rst_grant", 32'(grant), 32'h01);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    req = '0;
    tick();

    // ---------------- long hold / timeout ----------------
    do_reset();
    req = 8'h20;
    tick();
    check("hold_first", 32'(grant), 32'h20);
`ifdef ARB_TIMEOUT_EN
    begin
      int held;
      held = 1;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (grant == 8'h20) held++;
      end
      check("to_held_cycles", 32'(held), 32'd16);
      tick();
      check("to_revoke_grant", 32'(grant), 32'h0);
      check("to_pulse", 32'(timeout), 32'h1);
      tick();
      check("to_regrant", 32'(grant), 32'h20);
      check("to_pulse_end", 32'(timeout), 32'h0);
    end
`else
    repeat (20) tick();
    check("nohold_grant", 32'(grant), 32'h20);
    check("nohold_timeout", 32'(timeout), 32'h0);
`endif
    req = '0;
    tick();
    check("final_idle", 32'(grant), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
